// File: rtl/fk_omni_scheduler.sv
// rtl/fk_omni_scheduler.sv - round-robin scheduler sharing one forward-kinematics engine among NREQ requesters
// Optional macro FKS_TIMEOUT_EN adds a WAIT-state abort timer that returns an error response.
module fk_omni_scheduler #(
   parameter int          NREQ        = 3,
   parameter int          TIMEOUT_CYC = 64,
   parameter logic [15:0] R_WHEEL_RST = 16'd100,
   parameter logic [15:0] R_BASE_RST  = 16'd200
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ*16-1:0]   req_v1,
   input  logic [NREQ*16-1:0]   req_v2,
   input  logic [NREQ*16-1:0]   req_v3,
   output logic [NREQ-1:0]      grant,
   input  logic                 cfg_we,
   input  logic [15:0]          cfg_r,
   input  logic [15:0]          cfg_R,
   output logic                 fk_start,
   output logic [15:0]          fk_v1,
   output logic [15:0]          fk_v2,
   output logic [15:0]          fk_v3,
   output logic [15:0]          fk_r,
   output logic [15:0]          fk_R,
   input  logic [31:0]          fk_Vx,
   input  logic [31:0]          fk_Vy,
   input  logic [31:0]          fk_omega,
   input  logic                 fk_done,
   output logic [NREQ-1:0]      rsp_valid,
   output logic [31:0]          rsp_Vx,
   output logic [31:0]          rsp_Vy,
   output logic [31:0]          rsp_omega,
   output logic                 rsp_err,
   output logic                 busy
);

   localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_RESP} state_t;

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0]  owner_q, owner_d;
   logic [NREQ-1:0]   grant_q, grant_d;
   logic [NREQ-1:0]   rsp_valid_q, rsp_valid_d;
   logic              fk_start_q, fk_start_d;
   logic              busy_q, busy_d;
   logic [15:0]       fk_v1_q, fk_v1_d;
   logic [15:0]       fk_v2_q, fk_v2_d;
   logic [15:0]       fk_v3_q, fk_v3_d;
   logic [15:0]       fk_r_q, fk_r_d;
   logic [15:0]       fk_R_q, fk_R_d;
   logic [15:0]       shadow_r_q, shadow_r_d;
   logic [15:0]       shadow_R_q, shadow_R_d;
   logic [31:0]       rsp_vx_q, rsp_vx_d;
   logic [31:0]       rsp_vy_q, rsp_vy_d;
   logic [31:0]       rsp_om_q, rsp_om_d;
`ifdef FKS_TIMEOUT_EN
   logic [15:0]       to_cnt_q, to_cnt_d;
   logic              rsp_err_q, rsp_err_d;
`endif

   logic              win_found;
   logic [IDX_W-1:0]  win_idx;
   logic [IDX_W:0]    scan_sum;
   logic [IDX_W-1:0]  scan_idx;

   // Search upward from rr_ptr, wrapping modulo NREQ; the first live request wins.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      scan_sum  = '0;
      scan_idx  = '0;
      for (int k = 0; k < NREQ; k++) begin
         scan_sum = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
         if (scan_sum >= (IDX_W+1)'(NREQ)) begin
            scan_sum = scan_sum - (IDX_W+1)'(NREQ);
         end
         scan_idx = scan_sum[IDX_W-1:0];
         if (!win_found && req[scan_idx]) begin
            win_found = 1'b1;
            win_idx   = scan_idx;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      owner_d     = owner_q;
      grant_d     = '0;
      rsp_valid_d = '0;
      fk_start_d  = 1'b0;
      fk_v1_d     = fk_v1_q;
      fk_v2_d     = fk_v2_q;
      fk_v3_d     = fk_v3_q;
      fk_r_d      = fk_r_q;
      fk_R_d      = fk_R_q;
      shadow_r_d  = shadow_r_q;
      shadow_R_d  = shadow_R_q;
      rsp_vx_d    = rsp_vx_q;
      rsp_vy_d    = rsp_vy_q;
      rsp_om_d    = rsp_om_q;
`ifdef FKS_TIMEOUT_EN
      to_cnt_d    = to_cnt_q;
      rsp_err_d   = rsp_err_q;
`endif

      if (cfg_we) begin
         shadow_r_d = cfg_r;
         shadow_R_d = cfg_R;
      end

      case (state_q)
         S_IDLE: begin
            if (win_found) begin
               state_d    = S_START;
               grant_d    = NREQ'(1) << win_idx;
               fk_start_d = 1'b1;
               owner_d    = win_idx;
               fk_v1_d    = req_v1[{win_idx, 4'b0000} +: 16];
               fk_v2_d    = req_v2[{win_idx, 4'b0000} +: 16];
               fk_v3_d    = req_v3[{win_idx, 4'b0000} +: 16];
               // Old shadow is used even if cfg_we lands on this same edge.
               fk_r_d     = shadow_r_q;
               fk_R_d     = shadow_R_q;
            end
         end
         S_START: begin
            state_d = S_WAIT;
`ifdef FKS_TIMEOUT_EN
            to_cnt_d = '0;
`endif
         end
         S_WAIT: begin
            if (fk_done) begin
               state_d     = S_RESP;
               rsp_valid_d = NREQ'(1) << owner_q;
               rsp_vx_d    = fk_Vx;
               rsp_vy_d    = fk_Vy;
               rsp_om_d    = fk_omega;
`ifdef FKS_TIMEOUT_EN
               rsp_err_d   = 1'b0;
`endif
            end
`ifdef FKS_TIMEOUT_EN
            else if (to_cnt_q == 16'(TIMEOUT_CYC - 1)) begin
               state_d     = S_RESP;
               rsp_valid_d = NREQ'(1) << owner_q;
               rsp_vx_d    = '0;
               rsp_vy_d    = '0;
               rsp_om_d    = '0;
               rsp_err_d   = 1'b1;
            end else begin
               to_cnt_d = to_cnt_q + 16'd1;
            end
`endif
         end
         S_RESP: begin
            state_d  = S_IDLE;
            rr_ptr_d = (owner_q == IDX_W'(NREQ - 1)) ? '0 : owner_q + 1'b1;
         end
         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         rr_ptr_q    <= '0;
         owner_q     <= '0;
         grant_q     <= '0;
         rsp_valid_q <= '0;
         fk_start_q  <= 1'b0;
         busy_q      <= 1'b0;
         fk_v1_q     <= '0;
         fk_v2_q     <= '0;
         fk_v3_q     <= '0;
         fk_r_q      <= R_WHEEL_RST;
         fk_R_q      <= R_BASE_RST;
         shadow_r_q  <= R_WHEEL_RST;
         shadow_R_q  <= R_BASE_RST;
         rsp_vx_q    <= '0;
         rsp_vy_q    <= '0;
         rsp_om_q    <= '0;
`ifdef FKS_TIMEOUT_EN
         to_cnt_q    <= '0;
         rsp_err_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         owner_q     <= owner_d;
         grant_q     <= grant_d;
         rsp_valid_q <= rsp_valid_d;
         fk_start_q  <= fk_start_d;
         busy_q      <= busy_d;
         fk_v1_q     <= fk_v1_d;
         fk_v2_q     <= fk_v2_d;
         fk_v3_q     <= fk_v3_d;
         fk_r_q      <= fk_r_d;
         fk_R_q      <= fk_R_d;
         shadow_r_q  <= shadow_r_d;
         shadow_R_q  <= shadow_R_d;
         rsp_vx_q    <= rsp_vx_d;
         rsp_vy_q    <= rsp_vy_d;
         rsp_om_q    <= rsp_om_d;
`ifdef FKS_TIMEOUT_EN
         to_cnt_q    <= to_cnt_d;
         rsp_err_q   <= rsp_err_d;
`endif
      end
   end

   assign grant     = grant_q;
   assign fk_start  = fk_start_q;
   assign fk_v1     = fk_v1_q;
   assign fk_v2     = fk_v2_q;
   assign fk_v3     = fk_v3_q;
   assign fk_r      = fk_r_q;
   assign fk_R      = fk_R_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_Vx    = rsp_vx_q;
   assign rsp_Vy    = rsp_vy_q;
   assign rsp_omega = rsp_om_q;
   assign busy      = busy_q;
`ifdef FKS_TIMEOUT_EN
   assign rsp_err   = rsp_err_q;
`else
   assign rsp_err   = 1'b0;
`endif

endmodule
